// File: rtl/gate_share_arbiter_pkg.sv
// Shared definitions for the gate-sharing scheduler: opcodes, FSM states, id width.
package gate_share_arbiter_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/gate_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import gate_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin : pick
    int pos;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin scheduler sharing one registered bitwise gate unit among N_REQ requesters.
// Optional per-requester grant counters are enabled by defining ARB_STATS_EN.
module gate_share_arbiter
  import gate_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] op_i,
  input  logic [W*N_REQ-1:0] a_i,
  input  logic [W*N_REQ-1:0] b_i,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               res_valid,
  output logic [2:0]         res_id,
  output logic [W-1:0]       res_y
`ifdef ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0] grant_cnt
`endif
);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d, id_q;
  logic [N_REQ-1:0] gnt_q;
  logic             res_valid_q;
  logic [IDX_W-1:0] res_id_q;
  logic [W-1:0]     res_y_q;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q, b_q;

  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  function automatic logic [W-1:0] gate_f(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign ptr_d = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= '0;
    end else begin
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (win_any) begin
          gnt_q   <= win_oh;
          id_q    <= win_idx;
          state_q <= ST_GNT;
        end
        ST_GNT: begin
          ptr_q   <= ptr_d;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          res_y_q     <= gate_f(op_q, a_q, b_q);
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operands are captured once at the grant decision; later input changes cannot reach the result.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && win_any) begin
      op_q <= op_i[3*win_idx +: 3];
      a_q  <= a_i[W*win_idx +: W];
      b_q  <= b_i[W*win_idx +: W];
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst)
        cnt_q[i] <= '0;
      else if (gnt_q[i] && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++)
      grant_cnt[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Self-checking bench for gate_share_arbiter: event-time model plus directed literal checks.
module tb_gate_share_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [3*N-1:0] op_i;
  logic [8*N-1:0] a_i, b_i;
  logic [N-1:0] gnt;
  logic         busy, res_valid;
  logic [2:0]   res_id;
  logic [7:0]   res_y;
`ifdef ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  gate_share_arbiter #(.N_REQ(N), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_y     (res_y)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] ref_gate(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // Model: tracks the edge index of each grant/result rather than FSM states.
  longint     ecnt = 0;
  longint     g_at = -10, r_at = -10, free_at = 0;
  bit         m_on = 1'b0;
  int         mptr = 0;
  logic [3:0] m_oh = '0;
  logic [2:0] pend_id = '0, m_res_id = '0;
  logic [7:0] pend_y = '0, m_res_y = '0;
  int         m_cnt [N];

  always @(posedge clk) begin
    ecnt++;
    if (rst) begin
      m_on = 1'b1; mptr = 0; free_at = ecnt + 1; g_at = -10; r_at = -10;
      m_res_id = '0; m_res_y = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_on) begin
      if (g_at == ecnt - 1) begin
        for (int i = 0; i < N; i++)
          if (m_oh[i] && m_cnt[i] < 65535) m_cnt[i]++;
      end
      if (r_at == ecnt) begin
        m_res_id = pend_id; m_res_y = pend_y;
      end
      if (ecnt >= free_at && req != '0) begin
        for (int k = 0; k < N; k++) begin
          int w;
          w = (mptr + k) % N;
          if (req[w]) begin
            m_oh = '0; m_oh[w] = 1'b1;
            pend_id = 3'(w);
            pend_y = ref_gate(op_i[3*w +: 3], a_i[8*w +: 8], b_i[8*w +: 8]);
            mptr = (w + 1) % N;
            break;
          end
        end
        g_at = ecnt; r_at = ecnt + 2; free_at = ecnt + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("gnt", gnt, (g_at == ecnt) ? m_oh : 4'b0000);
      chk("busy", busy, (g_at == ecnt) || (g_at == ecnt - 1));
      chk("res_valid", res_valid, r_at == ecnt);
      chk("res_id", res_id, m_res_id);
      chk("res_y", res_y, m_res_y);
`ifdef ARB_STATS_EN
      for (int i = 0; i < N; i++)
        chk("grant_cnt", grant_cnt[16*i +: 16], 16'(m_cnt[i]));
`endif
    end
  end

  task automatic do_op(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [3:0] g, output logic [2:0] rid, output logic [7:0] ry, output int lat);
    g = '0; rid = '0; ry = '0; lat = -1;
    op_i[3*idx +: 3] = op; a_i[8*idx +: 8] = a; b_i[8*idx +: 8] = b;
    req[idx] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; break; end
    end
    req[idx] = 1'b0;
    op_i[3*idx +: 3] = ~op; a_i[8*idx +: 8] = ~a; b_i[8*idx +: 8] = ~b;
    if (g != '0) begin
      for (int c = 1; c < 10; c++) begin
        @(negedge clk);
        if (res_valid) begin rid = res_id; ry = res_y; lat = c; break; end
      end
    end
    @(negedge clk);
  endtask

  logic [3:0] t4_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] t6_exp [8] = '{8'h33, 8'h88, 8'hEE, 8'h77, 8'h11, 8'h66, 8'h99, 8'h00};

  initial begin
    logic [3:0] g, seq [5];
    logic [2:0] rid;
    logic [7:0] ry;
    int lat, n, stamp [5];

    rst = 1'b0; req = '0; op_i = '0; a_i = '0; b_i = '0;

    // T1: reset with every request asserted
    @(negedge clk);
    rst = 1'b1; req = 4'hF;
    op_i = {4{3'd1}}; a_i = 32'h0F1E2D3C; b_i = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("t1_gnt", gnt, 4'b0000);
    chk("t1_busy", busy, 1'b0);
    chk("t1_res_valid", res_valid, 1'b0);
    chk("t1_res_y", res_y, 8'h00);
    rst = 1'b0;

    // T4: fairness with all requests held
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) begin seq[n] = gnt; stamp[n] = c; n++; end
    end
    req = '0;
    chk("t4_count", n, 5);
    for (int i = 0; i < n; i++) chk("t4_order", seq[i], t4_exp[i]);
    for (int i = 1; i < n; i++) chk("t4_spacing", stamp[i] - stamp[i-1], 3);
    repeat (4) @(negedge clk);

    // T2: single AND
    do_op(2, 3'd1, 8'hF0, 8'h3C, g, rid, ry, lat);
    chk("t2_gnt", g, 4'b0100);
    chk("t2_res_id", rid, 3'd2);
    chk("t2_res_y", ry, 8'h30);
    chk("t2_latency", lat, 2);
    chk("t2_model_res_y", m_res_y, 8'h30);

    // T3: NOT ignores b
    do_op(0, 3'd0, 8'hA5, 8'h00, g, rid, ry, lat);
    chk("t3_res_y_b00", ry, 8'h5A);
    chk("t3_res_id", rid, 3'd0);
    do_op(0, 3'd0, 8'hA5, 8'hFF, g, rid, ry, lat);
    chk("t3_res_y_bff", ry, 8'h5A);
    chk("t3_model_res_y", m_res_y, 8'h5A);

    // T5: reset during EXEC abandons the op and resets the pointer
    op_i[3 +: 3] = 3'd2; a_i[8 +: 8] = 8'h12; b_i[8 +: 8] = 8'h34;
    req = 4'b0010;
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; break; end
    end
    req = '0;
    chk("t5_first_gnt", g, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_res_valid", res_valid, 1'b0);
      @(negedge clk);
    end
    req = 4'b1001;
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; break; end
    end
    req = '0;
    chk("t5_gnt_from_ptr0", g, 4'b0001);
    repeat (4) @(negedge clk);

    // T6: every opcode including reserved
    for (int op = 0; op < 8; op++) begin
      do_op(op % 4, 3'(op), 8'hCC, 8'hAA, g, rid, ry, lat);
      chk("t6_res_y", ry, t6_exp[op]);
      chk("t6_res_id", rid, 3'(op % 4));
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
